tdm_channel_selector: RTL and testbench

Parametrised successor to the 2:1 information selector that drives LED from switch fields. It selects one of NCH channels, each W bits wide, and presents the selected channel on a registered output. Two modes are supported: manual selection by index, or automatic round-robin scanning with a programmable dwell time. A hold input freezes the display, and a one-cycle pulse marks every channel change. It sits between the switch/data fields in top and the LED/SEG drivers.

---
 rtl/tdm_channel_selector.sv | 109 ++++++++++
 tb/tb_tdm_channel_selector.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tdm_channel_selector.sv
// tdm_channel_selector
//   Selects one of NCH packed channels (W bits each) and presents it on
//   registered outputs. In manual mode the channel comes from sel. In scan
//   mode the channels are visited round-robin, and each one is shown for
//   DWELL cycles. While hold is high, all state is frozen. step pulses for
//   one cycle on every channel change.
//
// Ports
//   clk_2    in   system clock; all updates on the rising edge
//   reset    in   synchronous active-high reset; overrides hold
//   ch_data  in   packed channels, channel k = ch_data[k*W +: W]
//   mode     in   0 = manual (sel), 1 = auto scan
//   sel      in   manual channel index
//   hold     in   1 = freeze all state, step forced low
//   data_out out  registered data of the current channel
//   ch_out   out  registered index of the current channel
//   step     out  one-cycle pulse when ch_out changed on this edge
//   sel_err  out  registered; 1 when the last manual sel was >= NCH
module tdm_channel_selector #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned W     = 2,
  parameter int unsigned DWELL = 4,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NCH*W-1:0]  ch_data,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              hold,
  output logic [W-1:0]      data_out,
  output logic [SELW-1:0]   ch_out,
  output logic              step,
  output logic              sel_err
);

  localparam int unsigned     CW       = $clog2(DWELL + 1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  logic [SELW-1:0] ch_q,   ch_d;
  logic [W-1:0]    data_q, data_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic            step_q, step_d;
  logic            err_q,  err_d;
  logic [W-1:0]    data_sel;

  // Next-channel decision. Under hold, every default is kept and step is
  // forced low, so all state freezes in place.
  always_comb begin
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    step_d = 1'b0;
    if (!hold) begin
      if (!mode) begin
        cnt_d = '0;
        if (sel > LAST_CH) begin
          err_d = 1'b1;
        end else begin
          ch_d  = sel;
          err_d = 1'b0;
        end
      end else begin
        err_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      step_d = (ch_d != ch_q);
    end
  end

  // The data mux follows the next channel, so data_out always matches ch_out.
  // Indices >= NCH have no matching entry.
  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_d == SELW'(k)) data_sel = ch_data[k*W +: W];
    end
  end

  assign data_d = hold ? data_q : data_sel;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      ch_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign data_out = data_q;
  assign ch_out   = ch_q;
  assign step     = step_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_tdm_channel_selector.sv
// Scoreboard bench for tdm_channel_selector.
//   u0: NCH=4, W=2, DWELL=4 (manual, scan wrap, hold, reset during scan)
//   u1: NCH=3, W=2, DWELL=1 (out-of-range select, advance on every edge)
// Stimulus is applied on the falling edge. The expected outputs for the next
// rising edge are pushed at the same time, and a monitor per DUT pops and
// compares 1 time unit after each rising edge.
module tb_tdm_channel_selector;

  typedef struct {
    logic [1:0] ch;
    logic [1:0] dat;
    logic       st;
    logic       er;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0 signals
  logic       r0 = 1'b1, m0 = 1'b0, h0 = 1'b0;
  logic [1:0] s0 = '0;
  logic [7:0] cd0 = 8'b11_10_01_00;
  logic [1:0] do0, co0;
  logic       st0, er0;

  // DUT 1 signals
  logic       r1 = 1'b1, m1 = 1'b0, h1 = 1'b0;
  logic [1:0] s1 = '0;
  logic [5:0] cd1 = 6'b10_01_11;
  logic [1:0] do1, co1;
  logic       st1, er1;

  tdm_channel_selector #(.NCH(4), .W(2), .DWELL(4)) u0 (
    .clk_2(clk), .reset(r0), .ch_data(cd0), .mode(m0), .sel(s0), .hold(h0),
    .data_out(do0), .ch_out(co0), .step(st0), .sel_err(er0)
  );

  tdm_channel_selector #(.NCH(3), .W(2), .DWELL(1)) u1 (
    .clk_2(clk), .reset(r1), .ch_data(cd1), .mode(m1), .sel(s1), .hold(h1),
    .data_out(do1), .ch_out(co1), .step(st1), .sel_err(er1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   vid   = 0;

  task automatic chk(input string nm, input int id, input logic [1:0] act,
                     input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0.ch_out",   e.id, co0, e.ch);
      chk("u0.data_out", e.id, do0, e.dat);
      chk("u0.step",     e.id, {1'b0, st0}, {1'b0, e.st});
      chk("u0.sel_err",  e.id, {1'b0, er0}, {1'b0, e.er});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1.ch_out",   e.id, co1, e.ch);
      chk("u1.data_out", e.id, do1, e.dat);
      chk("u1.step",     e.id, {1'b0, st1}, {1'b0, e.st});
      chk("u1.sel_err",  e.id, {1'b0, er1}, {1'b0, e.er});
    end
  end

  task automatic v0(input logic rst, input logic md, input logic [1:0] sl,
                    input logic hd, input logic [7:0] cd,
                    input logic [1:0] ec, input logic [1:0] ed,
                    input logic es, input logic ee);
    exp_t e;
    @(negedge clk);
    r0 = rst; m0 = md; s0 = sl; h0 = hd; cd0 = cd;
    e.ch = ec; e.dat = ed; e.st = es; e.er = ee; e.id = vid++;
    q0.push_back(e);
  endtask

  task automatic v1(input logic rst, input logic md, input logic [1:0] sl,
                    input logic hd,
                    input logic [1:0] ec, input logic [1:0] ed,
                    input logic es, input logic ee);
    exp_t e;
    @(negedge clk);
    r1 = rst; m1 = md; s1 = sl; h1 = hd;
    e.ch = ec; e.dat = ed; e.st = es; e.er = ee; e.id = vid++;
    q1.push_back(e);
  endtask

  localparam logic [7:0] CD  = 8'b11_10_01_00;
  localparam logic [7:0] CDL = 8'b01_10_01_00;  // channel 3 changed to 01

  // Scan from channel 0 with DWELL=4: 22 edges, ending on ch 1 with cnt=2.
  int unsigned sc_ch[22] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1,1,1};
  bit          sc_st[22] = '{0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0};

  initial begin
    // ---------------- DUT 0 ----------------
    v0(1, 0, 0, 0, CD, 0, 0, 0, 0);
    v0(1, 0, 0, 0, CD, 0, 0, 0, 0);
    v0(0, 0, 2, 0, CD, 2, 2, 1, 0);
    v0(0, 0, 2, 0, CD, 2, 2, 0, 0);
    v0(0, 0, 3, 0, CD, 3, 3, 1, 0);
    v0(0, 0, 3, 0, CDL, 3, 1, 0, 0);   // live data change on same channel
    v0(0, 0, 0, 0, CD, 0, 0, 1, 0);
    for (int i = 0; i < 22; i++)
      v0(0, 1, 3, 0, CD, 2'(sc_ch[i]), 2'(sc_ch[i]), sc_st[i], 0);
    // hold on ch 1 at cnt=2; zeroed data must not leak through
    for (int i = 0; i < 10; i++)
      v0(0, 1, 0, 1, 8'h00, 1, 1, 0, 0);
    v0(0, 1, 0, 0, CD, 1, 1, 0, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 1, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);    // now cnt=3 on ch 2
    v0(1, 1, 0, 1, CD, 0, 0, 0, 0);    // reset while holding
    v0(0, 1, 0, 0, CD, 0, 0, 0, 0);
    v0(0, 1, 0, 0, CD, 0, 0, 0, 0);
    v0(0, 1, 0, 0, CD, 0, 0, 0, 0);
    v0(0, 1, 0, 0, CD, 1, 1, 1, 0);
    v0(0, 1, 0, 0, CD, 1, 1, 0, 0);    // cnt=1 on ch 1
    v0(0, 0, 2, 0, CD, 2, 2, 1, 0);    // scan->manual clears cnt
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);
    v0(0, 1, 0, 0, CD, 2, 2, 0, 0);
    v0(0, 1, 0, 0, CD, 3, 3, 1, 0);
    v0(0, 1, 0, 0, CD, 3, 3, 0, 0);
    // ---------------- DUT 1 (ch0=3, ch1=1, ch2=2) ----------------
    v1(1, 0, 0, 0, 0, 0, 0, 0);
    v1(0, 0, 1, 0, 1, 1, 1, 0);
    v1(0, 0, 3, 0, 1, 1, 0, 1);
    v1(0, 0, 3, 0, 1, 1, 0, 1);
    v1(0, 0, 0, 0, 0, 3, 1, 0);
    v1(0, 0, 3, 0, 0, 3, 0, 1);
    v1(0, 1, 3, 0, 1, 1, 1, 0);        // DWELL=1: advance every edge
    v1(0, 1, 3, 0, 2, 2, 1, 0);
    v1(0, 1, 3, 0, 0, 3, 1, 0);        // wraps past index 2, never 3
    v1(0, 1, 3, 0, 1, 1, 1, 0);
    v1(0, 0, 3, 0, 1, 1, 0, 1);
    v1(0, 0, 0, 1, 1, 1, 0, 1);        // hold keeps sel_err and channel
    v1(0, 0, 2, 1, 1, 1, 0, 1);
    v1(0, 0, 2, 0, 2, 2, 1, 0);

    repeat (3) @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
